// File: rtl/bus_wait_ctrl.sv
// Wait-state controller between an 8-bit core and RAM/ROM/IO regions.
// Inserts per-region wait cycles, waits for io_ack with a timeout, flags bus errors.
module bus_wait_ctrl #(
  parameter int unsigned IO_WAIT    = 2,
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_strobe,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rwb,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_sync,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        io_ack,
  output logic        ram_cs,
  output logic        rom_cs,
  output logic        io_cs,
  output logic        mem_we,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StIoAck} state_e;
  typedef enum logic [1:0] {RegRam, RegIo, RegRom} region_e;

  localparam logic [7:0] IoWaitC     = 8'(IO_WAIT);
  localparam logic [7:0] RomWaitC    = 8'(ROM_WAIT);
  localparam logic [7:0] TimeoutLast = 8'(IO_TIMEOUT - 1);

  state_e      state_q, state_d;
  region_e     region_q, region_d, req_region;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rwb_q, rwb_d;
  logic        fetch_q, fetch_d;
  logic        err_q, err_d;

  always_comb begin
    if (!cpu_addr[15]) begin
      req_region = RegRam;
    end else if (!cpu_addr[14]) begin
      req_region = RegIo;
    end else begin
      req_region = RegRom;
    end
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rwb_d    = rwb_q;
    fetch_d  = fetch_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_strobe) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          rwb_d    = cpu_rwb;
          region_d = req_region;
          // Opcode fetch from IO space is refused without touching the device.
          fetch_d  = (req_region == RegIo) && cpu_rwb && cpu_sync;
          tcnt_d   = 8'd0;
          unique case (req_region)
            RegIo:   wcnt_d = IoWaitC;
            RegRom:  wcnt_d = RomWaitC;
            default: wcnt_d = 8'd0;
          endcase
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (wcnt_q == 8'd0) begin
          state_d = StIdle;
          unique case (region_q)
            RegIo: begin
              if (fetch_q) begin
                rdata_d = 8'hFF;
                err_d   = 1'b1;
              end else begin
                tcnt_d  = 8'd0;
                state_d = StIoAck;
              end
            end
            RegRom: begin
              if (rwb_q) rdata_d = mem_rdata;
              else       err_d   = 1'b1;
            end
            default: begin
              if (rwb_q) rdata_d = mem_rdata;
            end
          endcase
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      StIoAck: begin
        tcnt_d = tcnt_q + 8'd1;
        // An ack arriving on the timeout cycle still wins.
        if (io_ack) begin
          if (rwb_q) rdata_d = mem_rdata;
          tcnt_d  = 8'd0;
          state_d = StIdle;
        end else if (tcnt_q == TimeoutLast) begin
          if (rwb_q) rdata_d = 8'hFF;
          err_d   = 1'b1;
          tcnt_d  = 8'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      region_q <= RegRam;
      wcnt_q   <= 8'd0;
      tcnt_q   <= 8'd0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      rwb_q    <= 1'b1;
      fetch_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rwb_q    <= rwb_d;
      fetch_q  <= fetch_d;
      err_q    <= err_d;
    end
  end

  logic in_access, in_ack;
  assign in_access = (state_q == StAccess);
  assign in_ack    = (state_q == StIoAck);

  assign cpu_rdata = rdata_q;
  assign cpu_rdy   = (state_q == StIdle);
  assign busy      = !cpu_rdy;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign bus_err   = err_q;
  assign ram_cs    = in_access && (region_q == RegRam);
  assign rom_cs    = in_access && (region_q == RegRom) && rwb_q;
  assign io_cs     = (in_access && (region_q == RegIo) && !fetch_q) || in_ack;
  assign mem_we    = !rwb_q && ((in_access && (region_q != RegRom)) || in_ack);

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Bench for bus_wait_ctrl: directed transaction table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_bus_wait_ctrl;

  localparam int IO_WAIT    = 2;
  localparam int ROM_WAIT   = 1;
  localparam int IO_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset, cpu_strobe, cpu_rwb, cpu_sync, io_ack;
  logic [15:0] cpu_addr, mem_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic        cpu_rdy, ram_cs, rom_cs, io_cs, mem_we, bus_err, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_wait_ctrl #(
    .IO_WAIT    (IO_WAIT),
    .ROM_WAIT   (ROM_WAIT),
    .IO_TIMEOUT (IO_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_strobe (cpu_strobe),
    .cpu_addr   (cpu_addr),
    .cpu_rwb    (cpu_rwb),
    .cpu_wdata  (cpu_wdata),
    .cpu_sync   (cpu_sync),
    .cpu_rdata  (cpu_rdata),
    .cpu_rdy    (cpu_rdy),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .io_ack     (io_ack),
    .ram_cs     (ram_cs),
    .rom_cs     (rom_cs),
    .io_cs      (io_cs),
    .mem_we     (mem_we),
    .bus_err    (bus_err),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (transaction view) ----------------
  int          m_active, m_k, m_w, m_reg;
  logic        m_rwb, m_fetch, m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  function automatic int region_of(input logic [15:0] a);
    if (a < 16'h8000) return 0;
    if (a < 16'hC000) return 1;
    return 2;
  endfunction

  // Called at each rising edge with the inputs the DUT is sampling.
  task automatic model_step();
    m_err = 1'b0;
    if (reset) begin
      m_active = 0; m_k = 0; m_w = 0; m_reg = 0; m_rwb = 1'b1; m_fetch = 1'b0;
      m_addr = 16'h0; m_wdata = 8'h0; m_rdata = 8'h0;
    end else if (m_active == 0) begin
      if (cpu_strobe) begin
        m_active = 1;
        m_k      = 1;
        m_reg    = region_of(cpu_addr);
        m_w      = (m_reg == 1) ? IO_WAIT : (m_reg == 2) ? ROM_WAIT : 0;
        m_rwb    = cpu_rwb;
        m_fetch  = (m_reg == 1) && cpu_rwb && cpu_sync;
        m_addr   = cpu_addr;
        m_wdata  = cpu_wdata;
      end
    end else if (m_k <= m_w + 1) begin
      if (m_k == m_w + 1) begin
        if (m_reg == 1 && !m_fetch) begin
          m_k++;
        end else begin
          m_active = 0;
          if (m_reg == 1) begin
            m_rdata = 8'hFF; m_err = 1'b1;
          end else if (m_rwb) begin
            m_rdata = mem_rdata;
          end else if (m_reg == 2) begin
            m_err = 1'b1;
          end
        end
      end else begin
        m_k++;
      end
    end else begin
      if (io_ack) begin
        if (m_rwb) m_rdata = mem_rdata;
        m_active = 0;
      end else if (m_k - m_w - 2 == IO_TIMEOUT - 1) begin
        if (m_rwb) m_rdata = 8'hFF;
        m_err    = 1'b1;
        m_active = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  function automatic logic [63:0] model_outs();
    logic acc, ack;
    acc = (m_active != 0) && (m_k <= m_w + 1);
    ack = (m_active != 0) && (m_k > m_w + 1);
    return {25'd0, m_rdata, m_addr, m_wdata, (m_active == 0), (m_active != 0),
            acc && m_reg == 0, acc && m_reg == 2 && m_rwb,
            (acc && m_reg == 1 && !m_fetch) || ack,
            !m_rwb && ((acc && m_reg != 2) || ack), m_err};
  endfunction

  function automatic logic [63:0] dut_outs();
    return {25'd0, cpu_rdata, mem_addr, mem_wdata, cpu_rdy, busy,
            ram_cs, rom_cs, io_cs, mem_we, bus_err};
  endfunction

  // ---------------- directed transaction table ----------------
  typedef struct {
    logic [15:0] addr;
    logic        rwb;
    logic [7:0]  wdata;
    logic        sync;
    logic [7:0]  mrd;
    int          ack_at;     // IO_ACK cycle index where io_ack is raised, -1 never
    int          exp_busy;
    logic [7:0]  exp_rdata;
    int          exp_err;
    logic [3:0]  exp_mask;   // ever-high {ram_cs, rom_cs, io_cs, mem_we}
  } vec_t;

  vec_t tbl[11];

  task automatic run_txn(input vec_t v, input int idx);
    int         b, errs;
    logic [3:0] mask;
    cpu_strobe = 1'b1; cpu_addr = v.addr; cpu_rwb = v.rwb; cpu_wdata = v.wdata;
    cpu_sync = v.sync; mem_rdata = v.mrd; io_ack = 1'b0;
    tick();
    cpu_strobe = 1'b0;
    b = 0; errs = 0; mask = 4'b0000;
    while (!cpu_rdy && b < 40) begin
      mask |= {ram_cs, rom_cs, io_cs, mem_we};
      errs += int'(bus_err);
      io_ack = (v.ack_at >= 0) && (b == IO_WAIT + 1 + v.ack_at);
      tick();
      b++;
    end
    io_ack = 1'b0;
    errs += int'(bus_err);
    chk($sformatf("txn%0d_rdata", idx), 64'(cpu_rdata), 64'(v.exp_rdata));
    tick();
    errs += int'(bus_err);
    chk($sformatf("txn%0d_busy_cycles", idx), 64'(b), 64'(v.exp_busy));
    chk($sformatf("txn%0d_bus_err_pulses", idx), 64'(errs), 64'(v.exp_err));
    chk($sformatf("txn%0d_cs_we_seen", idx), 64'(mask), 64'(v.exp_mask));
  endtask

  initial begin
    tbl[0]  = '{16'h1234, 1'b1, 8'h00, 1'b0, 8'h5A, -1,  1, 8'h5A, 0, 4'b1000};
    tbl[1]  = '{16'h7FFF, 1'b0, 8'h77, 1'b0, 8'hEE, -1,  1, 8'h5A, 0, 4'b1001};
    tbl[2]  = '{16'hC000, 1'b1, 8'h00, 1'b0, 8'hA5, -1,  2, 8'hA5, 0, 4'b0100};
    tbl[3]  = '{16'hC000, 1'b0, 8'h11, 1'b0, 8'h00, -1,  2, 8'hA5, 1, 4'b0000};
    tbl[4]  = '{16'h8000, 1'b1, 8'h00, 1'b0, 8'h3C,  2,  6, 8'h3C, 0, 4'b0010};
    tbl[5]  = '{16'hBFFF, 1'b0, 8'h55, 1'b0, 8'h00,  0,  4, 8'h3C, 0, 4'b0011};
    tbl[6]  = '{16'h8001, 1'b1, 8'h00, 1'b0, 8'h12, -1, 18, 8'hFF, 1, 4'b0010};
    tbl[7]  = '{16'h0000, 1'b1, 8'h00, 1'b0, 8'h42, -1,  1, 8'h42, 0, 4'b1000};
    tbl[8]  = '{16'h8000, 1'b1, 8'h00, 1'b1, 8'h77, -1,  3, 8'hFF, 1, 4'b0000};
    tbl[9]  = '{16'hA000, 1'b1, 8'h00, 1'b0, 8'h99, 14, 18, 8'h99, 0, 4'b0010};
    tbl[10] = '{16'hFFFF, 1'b1, 8'h00, 1'b1, 8'hE1, -1,  2, 8'hE1, 0, 4'b0100};

    reset = 1'b1; cpu_strobe = 1'b0; cpu_addr = 16'h0; cpu_rwb = 1'b1;
    cpu_wdata = 8'h0; cpu_sync = 1'b0; mem_rdata = 8'h0; io_ack = 1'b0;
    tick();
    tick();
    chk("reset_state", dut_outs(), {25'd0, 8'h00, 16'h0000, 8'h00, 7'b1000000});
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_txn(tbl[i], i);

    // Reset during IO_ACK; a strobe during the access is ignored.
    cpu_strobe = 1'b1; cpu_addr = 16'h8000; cpu_rwb = 1'b1; cpu_sync = 1'b0;
    mem_rdata = 8'h3C;
    tick();
    cpu_addr = 16'h0010;
    tick();
    cpu_strobe = 1'b0;
    tick();
    tick();
    tick();
    chk("ioack_before_reset", {io_cs, cpu_rdy, mem_addr}, {1'b1, 1'b0, 16'h8000});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_ioack", {cpu_rdy, busy, io_cs, cpu_rdata, mem_addr},
        {1'b1, 1'b0, 1'b0, 8'h00, 16'h0000});

    // Strobe on the completion cycle is ignored.
    cpu_strobe = 1'b1; cpu_addr = 16'h0100; cpu_rwb = 1'b1; mem_rdata = 8'h6B;
    tick();
    cpu_addr = 16'h0200;
    chk("ram_access_cycle", {ram_cs, cpu_rdy}, {1'b1, 1'b0});
    tick();
    cpu_strobe = 1'b0;
    chk("ram_done", {cpu_rdy, cpu_rdata, mem_addr}, {1'b1, 8'h6B, 16'h0100});
    tick();
    chk("strobe_at_return_ignored", {cpu_rdy, ram_cs}, {1'b1, 1'b0});

    // Strobe coincident with reset is discarded.
    reset = 1'b1; cpu_strobe = 1'b1; cpu_addr = 16'h1234;
    tick();
    reset = 1'b0; cpu_strobe = 1'b0;
    chk("strobe_with_reset", {cpu_rdy, mem_addr}, {1'b1, 16'h0000});
    tick();
    chk("strobe_with_reset_idle", {cpu_rdy, ram_cs}, {1'b1, 1'b0});

    // Randomized traffic against the reference model.
    reset = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rand_cycle%0d", c), dut_outs(), model_outs());
      reset      = (c == 0) || ($urandom_range(0, 99) == 0);
      cpu_strobe = ($urandom_range(0, 2) == 0);
      cpu_addr   = 16'($urandom);
      cpu_rwb    = 1'($urandom);
      cpu_wdata  = 8'($urandom);
      cpu_sync   = 1'($urandom);
      mem_rdata  = 8'($urandom);
      io_ack     = ($urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
